// File: rtl/packet_arbiter_pkg.sv
// rtl/packet_arbiter_pkg.sv - shared constants and FSM state encoding for the packet arbiter
package packet_arbiter_pkg;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 16;

    typedef logic [0:0] arb_state_t;

    localparam arb_state_t ST_IDLE   = 1'b0;
    localparam arb_state_t ST_STREAM = 1'b1;

endpackage

// File: rtl/pkt_fifo.sv
// rtl/pkt_fifo.sv - per-channel store-and-forward byte FIFO with packet count and overflow drop
module pkt_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              in_ready,
    output logic              pkt_avail,
    output logic              overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W:0] mem [DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic [AW:0]     pkt_cnt;
    logic            discard;

    logic full;
    logic empty;
    logic write_ok;
    logic drop;
    logic pop;
    logic pkt_inc;
    logic pkt_dec;

    // Extra pointer MSB tells a wrapped-full FIFO apart from an empty one.
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty     = (wr_ptr == rd_ptr);
    assign in_ready  = !full || discard;
    assign pkt_avail = (pkt_cnt != '0);

    assign write_ok = wr_en && !full && !discard;
    assign drop     = wr_en && full && !discard && (pkt_cnt == '0);
    assign pop      = rd_en && !empty;

    assign {rd_last, rd_data} = mem[rd_ptr[AW-1:0]];

    assign pkt_inc = write_ok && wr_last;
    assign pkt_dec = pop && rd_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pkt_cnt  <= '0;
            discard  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            overflow <= drop;
            if (drop) begin
                // A packet too large to ever complete is flushed; the rest of it is
                // swallowed unless the dropped byte was already its end.
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                pkt_cnt <= '0;
                discard <= !wr_last;
            end else begin
                if (write_ok) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (pkt_inc && !pkt_dec) begin
                    pkt_cnt <= pkt_cnt + 1'b1;
                end else if (pkt_dec && !pkt_inc) begin
                    pkt_cnt <= pkt_cnt - 1'b1;
                end
                if (discard && wr_en && wr_last) begin
                    discard <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (write_ok) begin
            mem[wr_ptr[AW-1:0]] <= {wr_last, wr_data};
        end
    end

endmodule

// File: rtl/packet_arbiter.sv
// rtl/packet_arbiter.sv - round-robin packet-atomic arbiter over per-channel packet FIFOs
module packet_arbiter
    import packet_arbiter_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          in_we,
    input  logic [NUM_CH*DATA_W-1:0]   in_data,
    input  logic [NUM_CH-1:0]          in_last,
    output logic [NUM_CH-1:0]          in_ready,
    output logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_last,
    input  logic                       out_r_en,
    output logic [$clog2(NUM_CH)-1:0]  grant_ch,
    output logic [NUM_CH-1:0]          overflow_err
);

    localparam int CH_W = $clog2(NUM_CH);

    arb_state_t          state;
    logic [CH_W-1:0]     last_grant;
    logic [CH_W-1:0]     next_ch;
    logic                found;
    logic [NUM_CH-1:0]   eligible;
    logic [NUM_CH-1:0]   fifo_rd;
    logic [NUM_CH-1:0]   ch_last;
    logic [DATA_W-1:0]   ch_data [NUM_CH];
    logic                pop;
    logic                head_last;
    logic [DATA_W-1:0]   head_data;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        pkt_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .wr_en     (in_we[c]),
            .wr_data   (in_data[c*DATA_W +: DATA_W]),
            .wr_last   (in_last[c]),
            .rd_en     (fifo_rd[c]),
            .rd_data   (ch_data[c]),
            .rd_last   (ch_last[c]),
            .in_ready  (in_ready[c]),
            .pkt_avail (eligible[c]),
            .overflow  (overflow_err[c])
        );
    end

    // Walk downward so the nearest channel after last_grant is the one left standing.
    always_comb begin
        int idx;
        found   = 1'b0;
        next_ch = last_grant;
        idx     = 0;
        for (int i = NUM_CH; i >= 1; i--) begin
            idx = (int'(last_grant) + i) % NUM_CH;
            if (eligible[idx[CH_W-1:0]]) begin
                found   = 1'b1;
                next_ch = idx[CH_W-1:0];
            end
        end
    end

    assign head_data = ch_data[grant_ch];
    assign head_last = ch_last[grant_ch];

    assign out_ready = (state == ST_STREAM);
    assign out_data  = out_ready ? head_data : '0;
    assign out_last  = out_ready && head_last;
    assign pop       = out_ready && out_r_en;

    always_comb begin
        fifo_rd = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            fifo_rd[c] = pop && (grant_ch == CH_W'(c));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= CH_W'(NUM_CH - 1);
            grant_ch   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        grant_ch <= next_ch;
                        state    <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (pop && head_last) begin
                        last_grant <= grant_ch;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_packet_arbiter.sv
// tb/tb_packet_arbiter.sv - scoreboard bench for packet_arbiter
module tb_packet_arbiter;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    logic                      clk;
    logic                      rst;
    logic [NUM_CH-1:0]         in_we;
    logic [NUM_CH*DATA_W-1:0]  in_data;
    logic [NUM_CH-1:0]         in_last;
    logic [NUM_CH-1:0]         in_ready;
    logic                      out_ready;
    logic [DATA_W-1:0]         out_data;
    logic                      out_last;
    logic                      out_r_en;
    logic [1:0]                grant_ch;
    logic [NUM_CH-1:0]         overflow_err;

    packet_arbiter #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .in_we        (in_we),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .out_r_en     (out_r_en),
        .grant_ch     (grant_ch),
        .overflow_err (overflow_err)
    );

    typedef struct packed {
        logic [1:0] ch;
        logic       last;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   ov_cnt [NUM_CH];
    logic [4:0] occ2;

    assign occ2 = u_dut.g_ch[2].u_fifo.wr_ptr - u_dut.g_ch[2].u_fifo.rd_ptr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_byte(input int ch, input logic [7:0] d, input logic last);
        exp_t e;
        e.ch   = 2'(ch);
        e.last = last;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic put(input logic [3:0] we, input logic [31:0] data, input logic [3:0] last);
        in_we   = we;
        in_data = data;
        in_last = last;
        @(posedge clk);
        #1;
        in_we   = '0;
        in_last = '0;
    endtask

    task automatic wr1(input int ch, input logic [7:0] d, input logic last);
        logic [31:0] bus;
        logic [3:0]  we;
        bus = '0;
        bus[ch*8 +: 8] = d;
        we = 4'b0001 << ch;
        put(we, bus, last ? we : 4'b0000);
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
            @(posedge clk);
        end
        #1;
        check(tag, exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (overflow_err[c]) ov_cnt[c]++;
            end
            if (out_ready && out_r_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", exp_q.size(), 1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_data", 32'(out_data), 32'(e.data));
                    check("out_last", 32'(out_last), 32'(e.last));
                    check("grant_ch", 32'(grant_ch), 32'(e.ch));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int c = 0; c < NUM_CH; c++) ov_cnt[c] = 0;
        rst      = 1'b1;
        in_we    = '0;
        in_data  = '0;
        in_last  = '0;
        out_r_en = 1'b0;

        @(negedge clk);
        check("rst_out_ready", out_ready, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_in_ready", in_ready, 4'hF);
        check("rst_overflow", overflow_err, 0);
        check("rst_grant", grant_ch, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Three-byte packet on ch0 and its two-edge latency
        out_r_en = 1'b1;
        expect_byte(0, 8'h11, 0);
        expect_byte(0, 8'h22, 0);
        expect_byte(0, 8'h33, 1);
        wr1(0, 8'h11, 0);
        wr1(0, 8'h22, 0);
        wr1(0, 8'h33, 1);
        @(negedge clk);
        check("lat_edge1", out_ready, 0);
        @(negedge clk);
        check("lat_edge2", out_ready, 1);
        drain("s1_drain", 20);
        check("s1_idle", out_ready, 0);

        // Round-robin order with last_grant=1: ch2 before ch1
        expect_byte(1, 8'h5A, 1);
        wr1(1, 8'h5A, 1);
        drain("s2_prime", 20);
        out_r_en = 1'b0;
        expect_byte(2, 8'hB1, 0);
        expect_byte(2, 8'hB2, 1);
        expect_byte(1, 8'hA1, 0);
        expect_byte(1, 8'hA2, 1);
        put(4'b0110, {8'h00, 8'hB1, 8'hA1, 8'h00}, 4'b0000);
        put(4'b0110, {8'h00, 8'hB2, 8'hA2, 8'h00}, 4'b0110);
        repeat (2) @(posedge clk);
        #1;
        check("s2_grant", grant_ch, 2);
        check("s2_ready", out_ready, 1);
        out_r_en = 1'b1;
        drain("s2_drain", 30);

        // Overflow on ch3 with no complete packet buffered
        out_r_en = 1'b0;
        for (int i = 0; i < DEPTH; i++) wr1(3, 8'h30 + 8'(i), 0);
        check("s3_full_ready", in_ready[3], 0);
        check("s3_no_ov_yet", overflow_err[3], 0);
        wr1(3, 8'hEE, 0);
        check("s3_ov_pulse", overflow_err[3], 1);
        check("s3_discard_ready", in_ready[3], 1);
        wr1(3, 8'hE1, 0);
        check("s3_ov_single", overflow_err[3], 0);
        wr1(3, 8'hE2, 1);
        repeat (3) @(posedge clk);
        #1;
        check("s3_ov_count", ov_cnt[3], 1);
        check("s3_not_eligible", out_ready, 0);
        expect_byte(3, 8'hC1, 0);
        expect_byte(3, 8'hC2, 1);
        wr1(3, 8'hC1, 0);
        wr1(3, 8'hC2, 1);
        out_r_en = 1'b1;
        drain("s3_drain", 20);

        // Full ch0 holding a complete packet back-pressures instead of dropping
        out_r_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_byte(0, 8'h40 + 8'(i), i == 3);
            wr1(0, 8'h40 + 8'(i), i == 3);
        end
        for (int i = 0; i < 12; i++) begin
            expect_byte(0, 8'h50 + 8'(i), 0);
            wr1(0, 8'h50 + 8'(i), 0);
        end
        check("s4_full_ready", in_ready[0], 0);
        wr1(0, 8'hFF, 0);
        check("s4_no_ov", overflow_err[0], 0);
        @(negedge clk);
        check("s4_ov_count", ov_cnt[0], 0);
        @(posedge clk);
        #1 out_r_en = 1'b1;
        @(posedge clk);
        #1 out_r_en = 1'b0;
        check("s4_ready_after_pop", in_ready[0], 1);
        expect_byte(0, 8'h5C, 1);
        wr1(0, 8'h5C, 1);
        out_r_en = 1'b1;
        drain("s4_drain", 60);

        // Reset in the middle of streaming a 5-byte packet
        out_r_en = 1'b0;
        for (int i = 0; i < 5; i++) wr1(1, 8'h61 + 8'(i), i == 4);
        expect_byte(1, 8'h61, 0);
        expect_byte(1, 8'h62, 0);
        repeat (2) @(posedge clk);
        #1 out_r_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 out_r_en = 1'b0;
        check("s5_partial_popped", exp_q.size(), 0);
        #1 rst = 1'b1;
        #1;
        check("s5_rst_out_ready", out_ready, 0);
        check("s5_rst_in_ready", in_ready, 4'hF);
        check("s5_rst_out_data", out_data, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        out_r_en = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("s5_no_residue", out_ready, 0);

        // Concurrent write and pop on the granted channel
        out_r_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            expect_byte(2, 8'h80 + 8'(i), i == 9);
            wr1(2, 8'h80 + 8'(i), i == 9);
        end
        repeat (2) @(posedge clk);
        #1;
        check("s6_occ_pre", occ2, 10);
        out_r_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            expect_byte(2, 8'h90 + 8'(i), 0);
            wr1(2, 8'h90 + 8'(i), 0);
            check("s6_occ", occ2, 10);
        end
        expect_byte(2, 8'h98, 1);
        wr1(2, 8'h98, 1);
        drain("s6_drain", 60);

        check("ov_other_channels", ov_cnt[0] + ov_cnt[1] + ov_cnt[2], 0);
        check("final_queue", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
